// File: rtl/sargantana_icache_pkg.sv
// sargantana_icache_pkg: shared refill FSM state type and line geometry helper.
package sargantana_icache_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DRAIN} ifill_state_t;
  function automatic int beats_per_line(input int line_width, input int beat_width);
    return line_width / beat_width;
  endfunction
endpackage

// File: rtl/sargantana_icache_ifill_if.sv
// sargantana_icache_ifill_if: L2 line request / beat response bus.
// master (refill engine): drives req_valid/req_addr, receives req_ready and resp_*.
// slave (L2 side): the reverse.
interface sargantana_icache_ifill_if #(
  parameter int ADDR_W = 26,
  parameter int BEAT_W = 128
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic [BEAT_W-1:0] resp_data;
  logic              resp_err;
  modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_data, resp_err);
  modport slave  (input req_valid, req_addr, output req_ready, resp_valid, resp_data, resp_err);
endinterface

// File: rtl/sargantana_icache_linebuf.sv
// sargantana_icache_linebuf: beat-indexed line assembly buffer.
// Ports: clk_i/rst_i; we_i writes beat_i into slot beat_idx_i; line_o is the whole line.
module sargantana_icache_linebuf #(
  parameter int LINE_WIDTH = 512,
  parameter int BEAT_WIDTH = 128,
  parameter int CNT_W      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [CNT_W-1:0]      beat_idx_i,
  input  logic [BEAT_WIDTH-1:0] beat_i,
  output logic [LINE_WIDTH-1:0] line_o
);
  logic [LINE_WIDTH-1:0] line_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) line_q <= '0;
    else if (we_i) line_q[int'(beat_idx_i)*BEAT_WIDTH +: BEAT_WIDTH] <= beat_i;
  assign line_o = line_q;
endmodule

// File: rtl/sargantana_icache_ifill.sv
// sargantana_icache_ifill: icache refill engine (miss capture, L2 request, beat assembly, array write).
// Ports: clk_i/rst_i; miss_* from lookup stage; flush_i kills the refill; l2 bus (master);
// fill_* array write port; busy_o refill in progress; done_o/xcpt_o completion pulses.
module sargantana_icache_ifill
  import sargantana_icache_pkg::*;
#(
  parameter int ICACHE_N_WAY     = 4,
  parameter int ICACHE_TAG_WIDTH = 20,
  parameter int ICACHE_IDX_WIDTH = 6,
  parameter int LINE_WIDTH       = 512,
  parameter int BEAT_WIDTH       = 128,
  localparam int WAY_W           = $clog2(ICACHE_N_WAY)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        miss_i,
  input  logic [ICACHE_TAG_WIDTH-1:0] miss_tag_i,
  input  logic [ICACHE_IDX_WIDTH-1:0] miss_idx_i,
  input  logic [WAY_W-1:0]            miss_way_i,
  input  logic                        flush_i,
  sargantana_icache_ifill_if.master   l2,
  output logic                        fill_we_o,
  output logic [WAY_W-1:0]            fill_way_o,
  output logic [ICACHE_IDX_WIDTH-1:0] fill_idx_o,
  output logic [ICACHE_TAG_WIDTH-1:0] fill_tag_o,
  output logic [LINE_WIDTH-1:0]       fill_data_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        xcpt_o
);
  localparam int N_BEATS = beats_per_line(LINE_WIDTH, BEAT_WIDTH);
  localparam int CNT_W   = $clog2(N_BEATS);
  ifill_state_t                state_q, state_d;
  logic [ICACHE_TAG_WIDTH-1:0] tag_q, tag_d;
  logic [ICACHE_IDX_WIDTH-1:0] idx_q, idx_d;
  logic [WAY_W-1:0]            way_q, way_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        kill_q, kill_d, err_q, err_d;
  logic                        last, buf_we;
  assign last = cnt_q == CNT_W'(N_BEATS - 1);
  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    idx_d        = idx_q;
    way_d        = way_q;
    cnt_d        = cnt_q;
    kill_d       = kill_q;
    err_d        = err_q;
    buf_we       = 1'b0;
    l2.req_valid = 1'b0;
    fill_we_o    = 1'b0;
    done_o       = 1'b0;
    xcpt_o       = 1'b0;
    case (state_q)
      IDLE: if (miss_i && !flush_i) begin
        tag_d   = miss_tag_i;
        idx_d   = miss_idx_i;
        way_d   = miss_way_i;
        cnt_d   = '0;
        kill_d  = 1'b0;
        err_d   = 1'b0;
        state_d = REQ;
      end
      REQ: begin
        l2.req_valid = 1'b1;
        kill_d       = kill_q | flush_i;
        if (l2.req_ready) state_d = (kill_q || flush_i) ? DRAIN : WAIT;
      end
      WAIT: begin
        kill_d = kill_q | flush_i;
        if (l2.resp_valid) begin
          buf_we = 1'b1;
          cnt_d  = last ? '0 : cnt_q + 1'b1;
          err_d  = err_q | l2.resp_err;
        end
        // A flush on the last beat still finishes via WRITE, where the kill flag blocks the write.
        state_d = (l2.resp_valid && last) ? WRITE : flush_i ? DRAIN : WAIT;
      end
      DRAIN: if (l2.resp_valid) begin
        cnt_d  = last ? '0 : cnt_q + 1'b1;
        err_d  = err_q | l2.resp_err;
        if (last) begin
          done_o  = 1'b1;
          xcpt_o  = err_q | l2.resp_err;
          state_d = IDLE;
        end
      end
      WRITE: begin
        fill_we_o = !err_q && !kill_q && !flush_i;
        done_o    = 1'b1;
        xcpt_o    = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      tag_q   <= '0;
      idx_q   <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      err_q   <= err_d;
    end
  sargantana_icache_linebuf #(
    .LINE_WIDTH(LINE_WIDTH),
    .BEAT_WIDTH(BEAT_WIDTH),
    .CNT_W     (CNT_W)
  ) u_linebuf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (buf_we),
    .beat_idx_i(cnt_q),
    .beat_i    (l2.resp_data),
    .line_o    (fill_data_o)
  );
  assign l2.req_addr = {tag_q, idx_q};
  assign fill_way_o  = way_q;
  assign fill_idx_o  = idx_q;
  assign fill_tag_o  = tag_q;
  assign busy_o      = state_q != IDLE;
endmodule

// File: tb/tb_sargantana_icache_ifill.sv
// tb_sargantana_icache_ifill: directed self-checking bench for the icache refill engine.
module tb_sargantana_icache_ifill;
  localparam logic [127:0] B1 = {4{32'h11111111}};
  localparam logic [127:0] B2 = {4{32'h22222222}};
  localparam logic [127:0] B3 = {4{32'h33333333}};
  localparam logic [127:0] B4 = {4{32'h44444444}};
  localparam logic [127:0] C1 = {4{32'hA1A1A1A1}};
  localparam logic [127:0] C2 = {4{32'hB2B2B2B2}};
  localparam logic [127:0] C3 = {4{32'hC3C3C3C3}};
  localparam logic [127:0] C4 = {4{32'hD4D4D4D4}};
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         miss = 1'b0;
  logic [19:0]  miss_tag = '0;
  logic [5:0]   miss_idx = '0;
  logic [1:0]   miss_way = '0;
  logic         flush = 1'b0;
  logic         fill_we, busy, done, xcpt;
  logic [1:0]   fill_way;
  logic [5:0]   fill_idx;
  logic [19:0]  fill_tag;
  logic [511:0] fill_data;
  int total = 0;
  int bad   = 0;
  always #5 clk = ~clk;
  sargantana_icache_ifill_if #(.ADDR_W(26), .BEAT_W(128)) l2 ();
  sargantana_icache_ifill dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .miss_i     (miss),
    .miss_tag_i (miss_tag),
    .miss_idx_i (miss_idx),
    .miss_way_i (miss_way),
    .flush_i    (flush),
    .l2         (l2),
    .fill_we_o  (fill_we),
    .fill_way_o (fill_way),
    .fill_idx_o (fill_idx),
    .fill_tag_o (fill_tag),
    .fill_data_o(fill_data),
    .busy_o     (busy),
    .done_o     (done),
    .xcpt_o     (xcpt)
  );
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic start_miss(input logic [19:0] t, input logic [5:0] i, input logic [1:0] w);
    miss = 1'b1; miss_tag = t; miss_idx = i; miss_way = w;
    cyc();
    miss = 1'b0;
  endtask
  task automatic send_beat(input logic [127:0] d, input logic e);
    l2.resp_valid = 1'b1; l2.resp_data = d; l2.resp_err = e;
    cyc();
    l2.resp_valid = 1'b0; l2.resp_err = 1'b0;
  endtask
  initial begin
    l2.req_ready = 1'b0; l2.resp_valid = 1'b0; l2.resp_data = '0; l2.resp_err = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_req_valid", l2.req_valid, 0);
    chk("rst_fill_data", fill_data, 0);
    chk("rst_done", done | xcpt | fill_we, 0);
    @(negedge clk); rst = 1'b0;
    cyc();
    // clean refill, immediate ready, back-to-back beats
    l2.req_ready = 1'b1;
    start_miss(20'h12345, 6'h2A, 2'd2);
    #1;
    chk("t1_req_valid", l2.req_valid, 1);
    chk("t1_busy", busy, 1);
    chk("t1_addr", l2.req_addr, {20'h12345, 6'h2A});
    cyc();
    l2.req_ready = 1'b0;
    send_beat(B1, 0); send_beat(B2, 0); send_beat(B3, 0); send_beat(B4, 0);
    #1;
    chk("t1_fill_we", fill_we, 1);
    chk("t1_fill_way", fill_way, 2);
    chk("t1_fill_idx", fill_idx, 6'h2A);
    chk("t1_fill_tag", fill_tag, 20'h12345);
    chk("t1_fill_data", fill_data, {B4, B3, B2, B1});
    chk("t1_done", done, 1);
    chk("t1_xcpt", xcpt, 0);
    cyc();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_done", done | fill_we, 0);
    // backpressure and gapped beats
    start_miss(20'hABCDE, 6'h15, 2'd1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t2_valid_held", l2.req_valid, 1);
      cyc();
    end
    l2.req_ready = 1'b1;
    #1;
    chk("t2_valid_at_hs", l2.req_valid, 1);
    cyc();
    l2.req_ready = 1'b0;
    send_beat(C1, 0); repeat (3) cyc();
    send_beat(C2, 0); repeat (3) cyc();
    send_beat(C3, 0);
    #1;
    chk("t2_gap_busy", busy, 1);
    chk("t2_gap_no_we", fill_we, 0);
    repeat (3) cyc();
    send_beat(C4, 0);
    #1;
    chk("t2_fill_we", fill_we, 1);
    chk("t2_fill_data", fill_data, {C4, C3, C2, C1});
    chk("t2_fill_way", fill_way, 1);
    cyc();
    // flush after beat 1 drains without writing
    l2.req_ready = 1'b1;
    start_miss(20'h00001, 6'h01, 2'd3);
    cyc();
    l2.req_ready = 1'b0;
    send_beat(B1, 0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    chk("t3_drain_busy", busy, 1);
    send_beat(B2, 0); send_beat(B3, 0);
    l2.resp_valid = 1'b1; l2.resp_data = B4;
    #1;
    chk("t3_done", done, 1);
    chk("t3_xcpt", xcpt, 0);
    chk("t3_no_we", fill_we, 0);
    cyc();
    l2.resp_valid = 1'b0;
    #1;
    chk("t3_busy_after", busy, 0);
    chk("t3_no_we_after", fill_we | done, 0);
    // error on beat 2
    l2.req_ready = 1'b1;
    start_miss(20'h55555, 6'h3F, 2'd0);
    cyc();
    l2.req_ready = 1'b0;
    send_beat(B1, 0); send_beat(B2, 1); send_beat(B3, 0); send_beat(B4, 0);
    #1;
    chk("t4_no_we", fill_we, 0);
    chk("t4_done", done, 1);
    chk("t4_xcpt", xcpt, 1);
    cyc();
    // miss and flush together in IDLE
    miss = 1'b1; flush = 1'b1; miss_tag = 20'h77777;
    cyc();
    miss = 1'b0; flush = 1'b0;
    #1;
    chk("t5_no_busy", busy, 0);
    chk("t5_no_req", l2.req_valid, 0);
    // flush during REQ: handshake still completes, then drain
    start_miss(20'h0BEEF, 6'h10, 2'd1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    chk("t5_valid_after_flush", l2.req_valid, 1);
    l2.req_ready = 1'b1;
    cyc();
    l2.req_ready = 1'b0;
    #1;
    chk("t5_drain_busy", busy, 1);
    chk("t5_drain_no_req", l2.req_valid, 0);
    send_beat(C1, 0); send_beat(C2, 0); send_beat(C3, 0);
    l2.resp_valid = 1'b1; l2.resp_data = C4;
    #1;
    chk("t5_done", done, 1);
    chk("t5_no_we", fill_we, 0);
    cyc();
    l2.resp_valid = 1'b0;
    #1;
    chk("t5_idle", busy, 0);
    // asynchronous reset mid-refill, then a fresh refill
    l2.req_ready = 1'b1;
    start_miss(20'h0F0F0, 6'h0C, 2'd3);
    cyc();
    l2.req_ready = 1'b0;
    send_beat(C1, 0); send_beat(C2, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_data", fill_data, 0);
    chk("t6_rst_tag", fill_tag, 0);
    chk("t6_rst_way", fill_way, 0);
    chk("t6_rst_outs", {l2.req_valid, done, xcpt, fill_we}, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    l2.req_ready = 1'b1;
    start_miss(20'h12345, 6'h2A, 2'd2);
    cyc();
    l2.req_ready = 1'b0;
    send_beat(B4, 0); send_beat(B3, 0); send_beat(B2, 0); send_beat(B1, 0);
    #1;
    chk("t6_fill_we", fill_we, 1);
    chk("t6_fill_data", fill_data, {B1, B2, B3, B4});
    chk("t6_fill_tag", fill_tag, 20'h12345);
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
